reg_writeback: RTL and testbench
================================

# reg_writeback

Write-side companion to the operand fetch latches: it accepts ALU results tagged with a destination register address, buffers them in a small in-order queue, and drives the shared register bank's write port under a valid/ack handshake. It sits between the execute stage and the register bank. It also exposes a forwarding lookup so operand fetch can see results that are queued but not yet written into the bank.

## Interface
- DATA_W, 16, width of result data and register contents
- ADDR_W, 4, register address width (16 registers; reg0 is the accumulator, which is writable like any other)
- DEPTH, 2, queue entries; power of two, ≥2

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- res_valid  input  1  execute stage presents a result
- res_ready  output  1  block can accept a result this cycle
- res_addr  input  ADDR_W  destination register of the result
- res_data  input  DATA_W  result value
- flush  input  1  synchronous discard of all queued, unwritten results
- reg_wr_en  output  1  write request to the register bank
- reg_wr_addr  output  ADDR_W  write address
- reg_wr_data  output  DATA_W  write data
- reg_wr_ack  input  1  bank accepts the write this cycle
- fwd_addr  input  ADDR_W  register address being read by operand fetch
- fwd_hit  output  1  a queued entry targets fwd_addr
- fwd_data  output  DATA_W  data of the newest matching queued entry
- pending  output  clog2(DEPTH)+1  number of queued entries

## Operation
- Queue: circular buffer with write pointer, read pointer, and count.
- Push: on a rising edge with res_valid & res_ready, store {res_addr, res_data} at the write pointer. Pointers wrap modulo DEPTH.
- Pop: on a rising edge with reg_wr_en & reg_wr_ack, advance the read pointer.
- Ready: res_ready = (count < DEPTH) & ~flush. It is combinational from registered count. There is no pass-through when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both occur, and count is unchanged.
- Write port: reg_wr_en = (count != 0). reg_wr_addr/reg_wr_data are the head entry. They hold stable while reg_wr_en=1 and reg_wr_ack=0.
- reg_wr_ack while reg_wr_en=0 is ignored.
- Ordering: writes reach the bank strictly in acceptance order. Consecutive writes to the same address are all performed; none are coalesced.
- Flush: on a rising edge with flush=1, count and both pointers go to 0. The pending push (blocked via res_ready) and any pop/ack that cycle are discarded. Flush does not retract a write the bank acked in that cycle; the bank treats ack as its own commit.
- Forwarding (combinational):
  - Scan all valid entries.
  - fwd_hit=1 if any entry has addr == fwd_addr.
  - fwd_data comes from the most recently pushed match.
  - The head entry currently on the write port counts as valid until its pop edge.
  - An incoming res_* in the same cycle is not forwarded.
  - With no hit, fwd_data = 0.
- Width: data is passed through unmodified; no arithmetic on data. count is width clog2(DEPTH)+1 so that DEPTH is representable.

## Timing
- Reset (rst_n=0, async): count=0, pointers=0, storage=0, res_ready=1 (unless flush), reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, fwd_hit=0, fwd_data=0, pending=0.
- Reset asserted mid-handshake: queue emptied immediately, and reg_wr_en drops without waiting for ack.
- Latency: result pushed at edge N gives reg_wr_en=1 with its data in the cycle after edge N, if the queue was empty.
- Earliest pop: edge N+1 if reg_wr_ack=1.
- Sustained throughput: 1 write/cycle with ack held high and a continuous res_valid stream.
- Forwarding: fwd_hit/fwd_data update in the same cycle as fwd_addr or queue state changes. There is no registered stage.

## Test plan
- Reset/idle: hold rst_n=0 → all outputs at reset values. Release with ack=1 and no valid → reg_wr_en stays 0 and pending=0.
- Single write: push addr=3, data=0x1234, with ack=1 → next cycle reg_wr_en=1, addr=3, data=0x1234. The following edge pops, then pending=0 and reg_wr_en=0.
- Backpressure/full:
  - Ack=0; push 0xAAAA→r1, then 0xBBBB→r2 → res_ready=0, pending=2, and the write port holds r1/0xAAAA stable.
  - A third valid with 0xCCCC is not accepted.
  - Raise ack → bank sees r1, then r2, in order.
- Forwarding priority: queue r5=0x0001, then r5=0x0002 (ack=0) with fwd_addr=5 → fwd_hit=1, fwd_data=0x0002. fwd_addr=6 → fwd_hit=0, fwd_data=0.
- Wrap-around: 10 back-to-back pushes of r0..r9 with data = i, with ack toggling 1/0 → bank receives all 10 in order, and pointers wrap without loss or duplication.
- Flush/reset mid-operation:
  - Queue 2 entries, assert flush with res_valid=1 → res_ready=0 that cycle, and pending=0 and reg_wr_en=0 after the edge.
  - Repeat with rst_n pulsed low asynchronously → outputs clear immediately.

Source files
------------

// File: rtl/reg_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_if
// Description : Result-in / register-write-out / forwarding bundle for
//               reg_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic                res_valid;
  logic                res_ready;
  logic [ADDR_W-1:0]   res_addr;
  logic [DATA_W-1:0]   res_data;
  logic                flush;
  logic                reg_wr_en;
  logic [ADDR_W-1:0]   reg_wr_addr;
  logic [DATA_W-1:0]   reg_wr_data;
  logic                reg_wr_ack;
  logic [ADDR_W-1:0]   fwd_addr;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic [c_cnt_w-1:0]  pending;

  modport master (
    output res_valid, res_addr, res_data, flush, reg_wr_ack, fwd_addr,
    input  res_ready, reg_wr_en, reg_wr_addr, reg_wr_data, fwd_hit, fwd_data, pending
  );

  modport slave (
    input  res_valid, res_addr, res_data, flush, reg_wr_ack, fwd_addr,
    output res_ready, reg_wr_en, reg_wr_addr, reg_wr_data, fwd_hit, fwd_data, pending
  );
endinterface
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : In-order result queue driving the register bank write port,
//               with combinational forwarding of queued, unwritten results.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  reg_writeback_if.slave   bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [ADDR_W-1:0]  r_addr [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_wr_en;
  logic               w_fwd_hit;
  logic [DATA_W-1:0]  w_fwd_data;
  logic [c_ptr_w-1:0] w_fwd_idx;

  // No pass-through when full: readiness depends only on the registered count.
  assign w_ready = (r_count < c_full) & ~bus.flush;
  assign w_push  = bus.res_valid & w_ready;
  assign w_wr_en = (r_count != '0);
  assign w_pop   = w_wr_en & bus.reg_wr_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_addr[g] <= '0;
          r_data[g] <= '0;
        end else if (w_push && (r_wr_ptr == c_ptr_w'(g))) begin
          r_addr[g] <= bus.res_addr;
          r_data[g] <= bus.res_data;
        end
      end
    end
  endgenerate

  // Oldest-to-newest scan so the most recently pushed match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fwd_idx = r_rd_ptr + c_ptr_w'(k);
      if ((c_cnt_w'(k) < r_count) && (r_addr[w_fwd_idx] == bus.fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_fwd_idx];
      end
    end
  end

  assign bus.res_ready   = w_ready;
  assign bus.reg_wr_en   = w_wr_en;
  assign bus.reg_wr_addr = r_addr[r_rd_ptr];
  assign bus.reg_wr_data = r_data[r_rd_ptr];
  assign bus.fwd_hit     = w_fwd_hit;
  assign bus.fwd_data    = w_fwd_data;
  assign bus.pending     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback
// Description : Scoreboard bench for reg_writeback against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic clk;
  logic rst_n;
  logic running;
  int   n_checks;
  int   n_fail;
  int   n_writes;
  logic m_accept;
  entry_t exp_q[$];

  reg_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  reg_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " res_ready"},   32'(bus.res_ready),   32'd1);
    chk({tag, " reg_wr_en"},   32'(bus.reg_wr_en),   32'd0);
    chk({tag, " reg_wr_addr"}, 32'(bus.reg_wr_addr), 32'd0);
    chk({tag, " reg_wr_data"}, 32'(bus.reg_wr_data), 32'd0);
    chk({tag, " fwd_hit"},     32'(bus.fwd_hit),     32'd0);
    chk({tag, " fwd_data"},    32'(bus.fwd_data),    32'd0);
    chk({tag, " pending"},     32'(bus.pending),     32'd0);
  endtask

  // Reference view of the current cycle, compared at the falling edge.
  always @(negedge clk) begin
    if (rst_n && running) begin
      logic exp_ready;
      logic exp_hit;
      logic [DATA_W-1:0] exp_fd;
      exp_ready = (exp_q.size() < DEPTH) && !bus.flush;
      m_accept  = bus.res_valid && exp_ready;
      chk("res_ready", 32'(bus.res_ready), 32'(exp_ready));
      chk("pending",   32'(bus.pending),   32'(exp_q.size()));
      chk("reg_wr_en", 32'(bus.reg_wr_en), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("wr_port_addr", 32'(bus.reg_wr_addr), 32'(exp_q[0].a));
        chk("wr_port_data", 32'(bus.reg_wr_data), 32'(exp_q[0].d));
      end
      exp_hit = 1'b0;
      exp_fd  = '0;
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
        if (!exp_hit && exp_q[k].a == bus.fwd_addr) begin
          exp_hit = 1'b1;
          exp_fd  = exp_q[k].d;
        end
      end
      chk("fwd_hit",  32'(bus.fwd_hit),  32'(exp_hit));
      chk("fwd_data", 32'(bus.fwd_data), 32'(exp_fd));
    end else begin
      m_accept = 1'b0;
    end
  end

  // Monitor: every acked write must be the oldest outstanding result.
  always @(negedge clk) begin
    #1;
    if (rst_n && running && bus.reg_wr_en && bus.reg_wr_ack) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("bank_addr", 32'(bus.reg_wr_addr), 32'(e.a));
        chk("bank_data", 32'(bus.reg_wr_data), 32'(e.d));
      end
    end
  end

  // Model state advance for the coming edge (after any pop above).
  always @(negedge clk) begin
    #2;
    if (rst_n && running) begin
      if (bus.flush) begin
        exp_q.delete();
      end else if (m_accept) begin
        exp_q.push_back('{a: bus.res_addr, d: bus.res_data});
      end
    end
  end

  task automatic cyc(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic ack, input logic fl, input logic [ADDR_W-1:0] fa);
    bus.res_valid  = v;
    bus.res_addr   = a;
    bus.res_data   = d;
    bus.reg_wr_ack = ack;
    bus.flush      = fl;
    bus.fwd_addr   = fa;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ack, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, ack, 1'b0, 4'd15);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int i;
    int n;
    int w0;
    n_checks = 0;
    n_fail   = 0;
    n_writes = 0;
    running  = 1'b0;
    m_accept = 1'b0;
    rst_n    = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_addr   = '0;
    bus.res_data   = '0;
    bus.flush      = 1'b0;
    bus.reg_wr_ack = 1'b1;
    bus.fwd_addr   = '0;
    @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    running = 1'b1;
    idle(1'b1, 3);

    // Single write with one-cycle latency
    cyc(1'b1, 4'd3, 16'h1234, 1'b1, 1'b0, 4'd3);
    idle(1'b1, 2);

    // Backpressure: third result rejected while full
    cyc(1'b1, 4'd1, 16'hAAAA, 1'b0, 1'b0, 4'd1);
    cyc(1'b1, 4'd2, 16'hBBBB, 1'b0, 1'b0, 4'd2);
    cyc(1'b1, 4'd7, 16'hCCCC, 1'b0, 1'b0, 4'd7);
    cyc(1'b1, 4'd7, 16'hCCCC, 1'b0, 1'b0, 4'd1);
    bus.res_valid = 1'b0;
    idle(1'b1, 3);

    // Forwarding priority: newest matching entry wins
    cyc(1'b1, 4'd5, 16'h0001, 1'b0, 1'b0, 4'd5);
    cyc(1'b1, 4'd5, 16'h0002, 1'b0, 1'b0, 4'd5);
    cyc(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd5);
    cyc(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd6);
    idle(1'b1, 3);

    // Wrap-around with toggling ack
    w0 = n_writes;
    i  = 0;
    n  = 0;
    while (i < 10 && n < 200) begin
      logic ok;
      ok = (exp_q.size() < DEPTH);
      cyc(1'b1, 4'(i), 16'(i), (n % 2) == 0, 1'b0, 4'(i));
      if (ok) i++;
      n++;
    end
    idle(1'b1, 4);
    chk("wrap_write_count", 32'(n_writes - w0), 32'd10);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Flush with entries queued, without and with a concurrent ack
    cyc(1'b1, 4'd8, 16'h0808, 1'b0, 1'b0, 4'd8);
    cyc(1'b1, 4'd9, 16'h0909, 1'b0, 1'b0, 4'd9);
    cyc(1'b1, 4'd10, 16'h0A0A, 1'b0, 1'b1, 4'd9);
    chk("flush_pending", 32'(bus.pending), 32'd0);
    chk("flush_wr_en", 32'(bus.reg_wr_en), 32'd0);
    cyc(1'b1, 4'd11, 16'h0B0B, 1'b0, 1'b0, 4'd11);
    cyc(1'b1, 4'd12, 16'h0C0C, 1'b0, 1'b0, 4'd12);
    cyc(1'b1, 4'd13, 16'h0D0D, 1'b1, 1'b1, 4'd12);
    idle(1'b1, 2);

    // Asynchronous reset mid-handshake
    cyc(1'b1, 4'd4, 16'h4444, 1'b0, 1'b0, 4'd4);
    cyc(1'b1, 4'd6, 16'h6666, 1'b0, 1'b0, 4'd4);
    bus.res_valid = 1'b0;
    async_reset();
    idle(1'b1, 2);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)), 16'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, 4'($urandom_range(0, 3)));
      if (k == 200) async_reset();
    end
    idle(1'b1, DEPTH + 3);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    chk("final_pending", 32'(bus.pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
